vme_bus_arbiter: RTL and testbench

VME_BUS_ARBITER -- requirements
Module: vme_bus_arbiter

---
 rtl/vme_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_vme_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vme_bus_arbiter.sv
// -----------------------------------------------------------------------------
// vme_bus_arbiter
//
// Purpose:
//   Arbitrates two requesters (a, b) onto one VME-style slave memory port.
//   Only one slave transaction is outstanding at a time. Arbitration is
//   round-robin. The FSM runs IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   The response (x_ack / x_rdata / x_err) is registered at the end of RESP.
//   The minimum latency from x_req high to x_ack high is therefore 4 cycles.
//
// Optional feature (macro VME_BUS_ARBITER_TIMEOUT_EN):
//   When defined, a 16-bit wait counter aborts WAIT after TIMEOUT cycles.
//   The aborted transaction completes with err = 1 and rdata = 0.
//   When undefined, WAIT is left only on a matching done, and x_err is 0.
//
// Parameters:
//   ADDR_W   address width in bits
//   TIMEOUT  maximum slave wait in cycles (1..65535)
//
// Ports:
//   Clk, rst_n           clock, asynchronous active-low reset
//   x_req/x_we/x_addr/x_wdata   requester x in {a,b}: request and payload
//   x_ack/x_rdata/x_err         requester x: completion pulse, read data, timeout
//   VMEAddr/VMEWrData    slave address / write data (held for the transaction)
//   VMERdMem/VMEWrMem    one-cycle read / write strobes to the slave
//   VMERdData            slave read data, valid with VMERdDone
//   VMERdDone/VMEWrDone  slave completion pulses
// -----------------------------------------------------------------------------
module vme_bus_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_ack,
    output logic [31:0]       a_rdata,
    output logic              a_err,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_ack,
    output logic [31:0]       b_rdata,
    output logic              b_err,

    output logic [ADDR_W-1:0] VMEAddr,
    output logic [31:0]       VMEWrData,
    output logic              VMERdMem,
    output logic              VMEWrMem,
    input  logic [31:0]       VMERdData,
    input  logic              VMERdDone,
    input  logic              VMEWrDone
);

    // Reject an out-of-range TIMEOUT at elaboration time.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("vme_bus_arbiter: TIMEOUT must lie in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_reg, state_next;

    // last_grant_reg is also the owner of the transaction in flight.
    // 0 = a, 1 = b.
    logic              last_grant_reg;
    logic              winner;
    logic              done_hit;
    logic              rd_mem, wr_mem;
    logic              resp_fire;

    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rdata_cap_reg;

`ifdef VME_BUS_ARBITER_TIMEOUT_EN
    logic [15:0]       cnt_reg;
    logic              expire;
    logic              err_cap_reg;

    assign expire = (cnt_reg == 16'(TIMEOUT - 1));
`endif

    // Round-robin: on contention the side that did not win last time wins.
    // With a single request pending, that requester wins.
    assign winner    = (a_req && b_req) ? ~last_grant_reg : ~a_req;
    assign done_hit  = we_reg ? VMEWrDone : VMERdDone;
    assign resp_fire = (state_reg == RESP);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state and strobes ----------------
    always_comb begin
        state_next = state_reg;
        rd_mem     = 1'b0;
        wr_mem     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (a_req || b_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                rd_mem     = ~we_reg;
                wr_mem     = we_reg;
                state_next = WAIT;
            end
            WAIT: begin
                // A matching done takes priority over expiry on the same cycle.
                if (done_hit) begin
                    state_next = RESP;
                end
`ifdef VME_BUS_ARBITER_TIMEOUT_EN
                else if (expire) begin
                    state_next = RESP;
                end
`endif
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- Request latch and response capture ----------------
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_cap_reg  <= '0;
`ifdef VME_BUS_ARBITER_TIMEOUT_EN
            err_cap_reg    <= 1'b0;
`endif
        end else begin
            // The payload is frozen at grant time, so requester-side changes
            // after the grant cannot disturb the transaction in flight.
            if (state_reg == IDLE && (a_req || b_req)) begin
                last_grant_reg <= winner;
                we_reg         <= winner ? b_we    : a_we;
                addr_reg       <= winner ? b_addr  : a_addr;
                wdata_reg      <= winner ? b_wdata : a_wdata;
            end
            if (state_reg == WAIT) begin
                if (done_hit) begin
                    rdata_cap_reg <= we_reg ? 32'd0 : VMERdData;
`ifdef VME_BUS_ARBITER_TIMEOUT_EN
                    err_cap_reg   <= 1'b0;
`endif
                end
`ifdef VME_BUS_ARBITER_TIMEOUT_EN
                else if (expire) begin
                    rdata_cap_reg <= 32'd0;
                    err_cap_reg   <= 1'b1;
                end
`endif
            end
        end
    end

`ifdef VME_BUS_ARBITER_TIMEOUT_EN
    // The counter reads 0 in the first WAIT cycle.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 16'd0;
        end else if (state_reg == ISSUE) begin
            cnt_reg <= 16'd0;
        end else if (state_reg == WAIT) begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end
`endif

    // ---------------- Per-requester registered response ----------------
    // Index 0 is requester a and index 1 is requester b.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_resp
        localparam logic SIDE = (gi == 1) ? 1'b1 : 1'b0;
        logic        ack_reg;
        logic [31:0] rdata_reg;
`ifdef VME_BUS_ARBITER_TIMEOUT_EN
        logic        err_reg;
`endif

        always_ff @(posedge Clk or negedge rst_n) begin
            if (!rst_n) begin
                ack_reg   <= 1'b0;
                rdata_reg <= 32'd0;
`ifdef VME_BUS_ARBITER_TIMEOUT_EN
                err_reg   <= 1'b0;
`endif
            end else begin
                ack_reg <= resp_fire && (last_grant_reg == SIDE);
                if (resp_fire && (last_grant_reg == SIDE)) begin
                    rdata_reg <= rdata_cap_reg;
`ifdef VME_BUS_ARBITER_TIMEOUT_EN
                    err_reg   <= err_cap_reg;
`endif
                end
            end
        end
    end

    assign a_ack     = g_resp[0].ack_reg;
    assign b_ack     = g_resp[1].ack_reg;
    assign a_rdata   = g_resp[0].rdata_reg;
    assign b_rdata   = g_resp[1].rdata_reg;
`ifdef VME_BUS_ARBITER_TIMEOUT_EN
    assign a_err     = g_resp[0].err_reg;
    assign b_err     = g_resp[1].err_reg;
`else
    assign a_err     = 1'b0;
    assign b_err     = 1'b0;
`endif

    assign VMEAddr   = addr_reg;
    assign VMEWrData = wdata_reg;
    assign VMERdMem  = rd_mem;
    assign VMEWrMem  = wr_mem;

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vme_bus_arbiter
//
// Purpose:
//   Directed bench for vme_bus_arbiter. The bench drives inputs and the slave
//   response by hand. Outputs are sampled 1 ns after each rising edge.
//   The timeout scenarios run only when VME_BUS_ARBITER_TIMEOUT_EN is defined.
//
// Ports:
//   None. This is the top-level testbench module.
// -----------------------------------------------------------------------------
module tb_vme_bus_arbiter;

    localparam int ADDR_W = 14;

    logic              Clk = 1'b0;
    logic              rst_n;
    logic              a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [31:0]       a_wdata, b_wdata;
    logic              a_ack, a_err, b_ack, b_err;
    logic [31:0]       a_rdata, b_rdata;
    logic [ADDR_W-1:0] VMEAddr;
    logic [31:0]       VMEWrData, VMERdData;
    logic              VMERdMem, VMEWrMem, VMERdDone, VMEWrDone;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    vme_bus_arbiter #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (8)
    ) dut (
        .Clk       (Clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .a_err     (a_err),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .b_err     (b_err),
        .VMEAddr   (VMEAddr),
        .VMEWrData (VMEWrData),
        .VMERdMem  (VMERdMem),
        .VMEWrMem  (VMEWrMem),
        .VMERdData (VMERdData),
        .VMERdDone (VMERdDone),
        .VMEWrDone (VMEWrDone)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        VMERdData = '0; VMERdDone = 1'b0; VMEWrDone = 1'b0;

        // ---------------- reset state ----------------
        tick();
        chk("rst_a_ack",   32'(a_ack), 0);
        chk("rst_b_ack",   32'(b_ack), 0);
        chk("rst_a_err",   32'(a_err), 0);
        chk("rst_rdmem",   32'(VMERdMem), 0);
        chk("rst_wrmem",   32'(VMEWrMem), 0);
        chk("rst_addr",    32'(VMEAddr), 0);
        chk("rst_wrdata",  VMEWrData, 0);
        chk("rst_a_rdata", a_rdata, 0);
        rst_n = 1'b1;

        // ---------------- single read, minimum latency ----------------
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010;
        tick();                                         // ISSUE
        chk("t1_rdmem",    32'(VMERdMem), 1);
        chk("t1_wrmem",    32'(VMEWrMem), 0);
        chk("t1_addr",     32'(VMEAddr), 32'h10);
        tick();                                         // WAIT
        chk("t1_rdmem_off", 32'(VMERdMem), 0);
        chk("t1_addr_hold", 32'(VMEAddr), 32'h10);
        VMERdDone = 1'b1; VMERdData = 32'h1234_5678;
        tick();                                         // RESP
        VMERdDone = 1'b0; VMERdData = 32'h0;
        chk("t1_ack_early", 32'(a_ack), 0);
        tick();                                         // ack cycle
        chk("t1_ack",      32'(a_ack), 1);
        chk("t1_rdata",    a_rdata, 32'h1234_5678);
        chk("t1_err",      32'(a_err), 0);
        chk("t1_b_ack",    32'(b_ack), 0);
        a_req = 1'b0;
        tick();
        chk("t1_ack_pulse", 32'(a_ack), 0);
        $display("[tb] txn a read addr=0010 rdata=%h", a_rdata);

        // ---------------- simultaneous writes after reset ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0100; a_wdata = 32'hAAAA_0001;
        b_req = 1'b1; b_we = 1'b1; b_addr = 14'h0200; b_wdata = 32'hBBBB_0002;
        tick();                                         // ISSUE for a
        chk("t2a_wrmem",   32'(VMEWrMem), 1);
        chk("t2a_rdmem",   32'(VMERdMem), 0);
        chk("t2a_addr",    32'(VMEAddr), 32'h100);
        chk("t2a_wdata",   VMEWrData, 32'hAAAA_0001);
        a_wdata = 32'h0BAD_BAD0; a_addr = 14'h3FFF;     // late change is ignored
        tick();                                         // WAIT
        chk("t2a_wdata_hold", VMEWrData, 32'hAAAA_0001);
        chk("t2a_addr_hold",  32'(VMEAddr), 32'h100);
        VMEWrDone = 1'b1;
        tick();
        VMEWrDone = 1'b0;
        tick();
        chk("t2a_ack",     32'(a_ack), 1);
        chk("t2a_b_ack",   32'(b_ack), 0);
        chk("t2a_rdata",   a_rdata, 0);
        a_req = 1'b0;
        $display("[tb] txn a write addr=0100");
        tick();                                         // ISSUE for b
        chk("t2b_wrmem",   32'(VMEWrMem), 1);
        chk("t2b_addr",    32'(VMEAddr), 32'h200);
        chk("t2b_wdata",   VMEWrData, 32'hBBBB_0002);
        tick();
        VMEWrDone = 1'b1;
        tick();
        VMEWrDone = 1'b0;
        tick();
        chk("t2b_ack",     32'(b_ack), 1);
        chk("t2b_a_ack",   32'(a_ack), 0);
        chk("t2b_rdata",   b_rdata, 0);
        b_req = 1'b0;
        $display("[tb] txn b write addr=0200");

        // ---------------- fairness: both requests held ----------------
        // The last grant went to b, so a is served first.
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h00A0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 14'h00B0;
        for (int k = 0; k < 6; k++) begin
            tick();                                     // ISSUE
            chk($sformatf("t3_rdmem_%0d", k), 32'(VMERdMem), 1);
            chk($sformatf("t3_addr_%0d", k), 32'(VMEAddr), (k % 2 == 0) ? 32'hA0 : 32'hB0);
            tick();                                     // WAIT
            VMERdDone = 1'b1; VMERdData = 32'hF000_0000 + 32'(k);
            tick();                                     // RESP
            VMERdDone = 1'b0;
            tick();                                     // ack cycle
            chk($sformatf("t3_a_ack_%0d", k), 32'(a_ack), (k % 2 == 0) ? 1 : 0);
            chk($sformatf("t3_b_ack_%0d", k), 32'(b_ack), (k % 2 == 0) ? 0 : 1);
            chk($sformatf("t3_rdata_%0d", k), (k % 2 == 0) ? a_rdata : b_rdata,
                32'hF000_0000 + 32'(k));
            $display("[tb] txn fair k=%0d a_ack=%0b b_ack=%0b", k, a_ack, b_ack);
        end
        a_req = 1'b0; b_req = 1'b0;

        // ---------------- wrong-direction done and done during ISSUE ----------------
        tick();
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0033;
        tick();                                         // ISSUE
        VMERdDone = 1'b1; VMERdData = 32'hDEAD_DEAD;    // arrives in ISSUE, ignored
        tick();                                         // WAIT
        VMERdDone = 1'b0;
        VMEWrDone = 1'b1;                               // wrong direction, ignored
        tick();                                         // still WAIT
        VMEWrDone = 1'b0;
        chk("t4_ack_none", 32'(a_ack), 0);
        chk("t4_no_strobe", 32'(VMERdMem), 0);
        VMERdDone = 1'b1; VMERdData = 32'hCAFE_F00D;
        tick();                                         // RESP
        VMERdDone = 1'b0;
        chk("t4_ack_early", 32'(a_ack), 0);
        tick();
        chk("t4_ack",      32'(a_ack), 1);
        chk("t4_rdata",    a_rdata, 32'hCAFE_F00D);
        chk("t4_err",      32'(a_err), 0);
        a_req = 1'b0;
        $display("[tb] txn a read addr=0033 rdata=%h", a_rdata);

        // ---------------- reset in WAIT, late done ----------------
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0044;
        tick();                                         // ISSUE
        tick();                                         // WAIT
        rst_n = 1'b0;
        a_req = 1'b0;
        #1;
        chk("t5_rst_addr", 32'(VMEAddr), 0);
        chk("t5_rst_rdmem", 32'(VMERdMem), 0);
        tick();
        tick();
        rst_n = 1'b1;
        VMERdDone = 1'b1; VMERdData = 32'h9999_9999;
        tick();
        VMERdDone = 1'b0;
        chk("t5_ack_none1", 32'(a_ack), 0);
        chk("t5_rdmem_none", 32'(VMERdMem), 0);
        tick();
        chk("t5_ack_none2", 32'(a_ack), 0);
        chk("t5_rdata_zero", a_rdata, 0);
        // The FSM is in IDLE, so a fresh request issues on the next edge.
        b_req = 1'b1; b_we = 1'b0; b_addr = 14'h0055;
        tick();
        chk("t5_b_rdmem",  32'(VMERdMem), 1);
        chk("t5_b_addr",   32'(VMEAddr), 32'h55);
        tick();
        VMERdDone = 1'b1; VMERdData = 32'h5555_AAAA;
        tick();
        VMERdDone = 1'b0;
        tick();
        chk("t5_b_ack",    32'(b_ack), 1);
        chk("t5_b_rdata",  b_rdata, 32'h5555_AAAA);
        b_req = 1'b0;
        $display("[tb] txn b read addr=0055 rdata=%h", b_rdata);

`ifdef VME_BUS_ARBITER_TIMEOUT_EN
        // ---------------- done on the expiry cycle wins ----------------
        tick();
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0066;
        tick();                                         // ISSUE
        for (int i = 0; i < 8; i++) begin
            tick();                                     // WAIT cycles with cnt 0..7
            chk($sformatf("t6_wait_%0d", i), 32'(a_ack), 0);
        end
        VMERdDone = 1'b1; VMERdData = 32'h7777_8888;    // present while cnt == 7
        tick();                                         // RESP
        VMERdDone = 1'b0;
        chk("t6_ack_early", 32'(a_ack), 0);
        tick();
        chk("t6_ack",      32'(a_ack), 1);
        chk("t6_err",      32'(a_err), 0);
        chk("t6_rdata",    a_rdata, 32'h7777_8888);
        a_req = 1'b0;
        $display("[tb] txn a read addr=0066 expiry-cycle done");

        // ---------------- full timeout ----------------
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0077;
        tick();                                         // ISSUE
        chk("t7_rdmem",    32'(VMERdMem), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t7_wait_%0d", i), 32'(a_ack), 0);
        end
        tick();                                         // RESP
        chk("t7_ack_early", 32'(a_ack), 0);
        tick();
        chk("t7_ack",      32'(a_ack), 1);
        chk("t7_err",      32'(a_err), 1);
        chk("t7_rdata",    a_rdata, 0);
        a_req = 1'b0;
        $display("[tb] txn a read addr=0077 timeout");

        // ---------------- next request is served normally ----------------
        b_req = 1'b1; b_we = 1'b1; b_addr = 14'h0088; b_wdata = 32'h1212_1212;
        tick();
        chk("t8_wrmem",    32'(VMEWrMem), 1);
        chk("t8_wdata",    VMEWrData, 32'h1212_1212);
        tick();
        VMEWrDone = 1'b1;
        tick();
        VMEWrDone = 1'b0;
        tick();
        chk("t8_ack",      32'(b_ack), 1);
        chk("t8_err",      32'(b_err), 0);
        chk("t8_rdata",    b_rdata, 0);
        b_req = 1'b0;
        $display("[tb] txn b write addr=0088");
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
